// File: rtl/battle_ctrl_n_if.sv
// Handshake bundle between the battle menu/datapath and the battle controller FSM.
// The master drives player commands and datapath status; the slave returns state, strobes and flags.
interface battle_ctrl_n_if #(
  parameter int PARTY_N = 3
);
  localparam int SLOT_W = $clog2(PARTY_N);

  logic               go;
  logic [1:0]         move_op;
  logic               p_faster;
  logic               ai_dead;
  logic [PARTY_N-1:0] party_alive;
  logic               catch_success;

  logic [3:0]         state_code;
  logic               apply_ai_damage;
  logic               apply_p_damage;
  logic               p_heal;
  logic               catch;
  logic               catch_fail;
  logic               switch_en;
  logic               victory;
  logic               loss;
  logic               caught;
  logic [SLOT_W-1:0]  active_slot;
  logic               catch_denied;

  modport master (
    output go, move_op, p_faster, ai_dead, party_alive, catch_success,
    input  state_code, apply_ai_damage, apply_p_damage, p_heal, catch, catch_fail,
           switch_en, victory, loss, caught, active_slot, catch_denied
  );

  modport slave (
    input  go, move_op, p_faster, ai_dead, party_alive, catch_success,
    output state_code, apply_ai_damage, apply_p_damage, p_heal, catch, catch_fail,
           switch_en, victory, loss, caught, active_slot, catch_denied
  );
endinterface

// File: rtl/battle_ctrl_n.sv
// Turn-based battle controller: sequences attack/heal/catch/switch turns, applies
// victory/loss/forced-switch overrides and Moore-decodes datapath strobes from state.
module battle_ctrl_n #(
  parameter int PARTY_N   = 3,
  parameter int MAX_CATCH = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  battle_ctrl_n_if.slave bus
);
  localparam int SLOT_W = $clog2(PARTY_N);
  localparam int CNT_W  = $clog2(MAX_CATCH + 1);

  typedef enum logic [3:0] {
    S_MENU      = 4'd0,
    S_PATK      = 4'd1,
    S_AIATK     = 4'd2,
    S_HEAL      = 4'd3,
    S_CATCH     = 4'd4,
    S_CATCHFAIL = 4'd5,
    S_SWITCH    = 4'd6,
    S_VICTORY   = 4'd7,
    S_LOSS      = 4'd8,
    S_CAUGHT    = 4'd9
  } state_t;

  state_t            r_state;
  logic [SLOT_W-1:0] r_slot;
  logic [CNT_W-1:0]  r_catchCnt;
  logic              r_forced;
  logic              r_pFaster;
  logic              r_pAtkPend;
  logic              r_catchDenied;

  state_t            w_stateNext;
  logic              w_forcedNext;
  logic              w_pFasterNext;
  logic              w_pAtkPendNext;
  logic              w_cntInc;
  logic              w_deniedNext;
  logic [SLOT_W-1:0] w_nextSlot;
  logic              w_otherAlive;
  logic              w_terminal;

  // Nearest alive slot after the active one; descending loop lets the smallest offset win.
  always_comb begin
    w_nextSlot   = r_slot;
    w_otherAlive = 1'b0;
    for (int k = PARTY_N - 1; k >= 1; k--) begin
      if (bus.party_alive[(int'(r_slot) + k) % PARTY_N]) begin
        w_nextSlot   = SLOT_W'((int'(r_slot) + k) % PARTY_N);
        w_otherAlive = 1'b1;
      end
    end
  end

  assign w_terminal = (r_state == S_VICTORY) || (r_state == S_LOSS) || (r_state == S_CAUGHT);

  always_comb begin
    w_stateNext    = r_state;
    w_forcedNext   = r_forced;
    w_pFasterNext  = r_pFaster;
    w_pAtkPendNext = 1'b0;
    w_cntInc       = 1'b0;
    w_deniedNext   = 1'b0;
    if (!w_terminal) begin
      if (bus.ai_dead) begin
        w_stateNext = S_VICTORY;
      end else if (bus.party_alive == '0) begin
        w_stateNext = S_LOSS;
      end else if (!bus.party_alive[r_slot] && (r_state != S_SWITCH)) begin
        w_stateNext  = S_SWITCH;
        w_forcedNext = 1'b1;
      end else begin
        case (r_state)
          S_MENU: begin
            if (bus.go) begin
              w_pFasterNext = bus.p_faster;
              case (bus.move_op)
                2'b00: begin
                  w_stateNext    = bus.p_faster ? S_PATK : S_AIATK;
                  w_pAtkPendNext = !bus.p_faster;
                end
                2'b01: begin
                  if (r_catchCnt < CNT_W'(MAX_CATCH)) begin
                    w_stateNext = S_CATCH;
                    w_cntInc    = 1'b1;
                  end else begin
                    w_deniedNext = 1'b1;
                  end
                end
                2'b10: begin
                  if (w_otherAlive) begin
                    w_stateNext  = S_SWITCH;
                    w_forcedNext = 1'b0;
                  end
                end
                default: w_stateNext = S_HEAL;
              endcase
            end
          end
          // A pending player attack exists only when the AI moved first in an attack turn.
          S_PATK:      w_stateNext = r_pFaster ? S_AIATK : S_MENU;
          S_AIATK:     w_stateNext = r_pAtkPend ? S_PATK : S_MENU;
          S_HEAL:      w_stateNext = S_AIATK;
          S_CATCH:     w_stateNext = bus.catch_success ? S_CAUGHT : S_CATCHFAIL;
          S_CATCHFAIL: w_stateNext = S_AIATK;
          S_SWITCH:    w_stateNext = r_forced ? S_MENU : S_AIATK;
          default:     w_stateNext = r_state;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_MENU;
      r_slot        <= '0;
      r_catchCnt    <= '0;
      r_forced      <= 1'b0;
      r_pFaster     <= 1'b0;
      r_pAtkPend    <= 1'b0;
      r_catchDenied <= 1'b0;
    end else begin
      r_state       <= w_stateNext;
      r_forced      <= w_forcedNext;
      r_pFaster     <= w_pFasterNext;
      r_pAtkPend    <= w_pAtkPendNext;
      r_catchDenied <= w_deniedNext;
      if (w_cntInc) begin
        r_catchCnt <= r_catchCnt + CNT_W'(1);
      end
      if ((r_state == S_SWITCH) && w_otherAlive) begin
        r_slot <= w_nextSlot;
      end
    end
  end

  assign bus.state_code      = r_state;
  assign bus.apply_ai_damage = (r_state == S_PATK);
  assign bus.apply_p_damage  = (r_state == S_AIATK);
  assign bus.p_heal          = (r_state == S_HEAL);
  assign bus.catch           = (r_state == S_CATCH);
  assign bus.catch_fail      = (r_state == S_CATCHFAIL);
  assign bus.switch_en       = (r_state == S_SWITCH);
  assign bus.victory         = (r_state == S_VICTORY);
  assign bus.loss            = (r_state == S_LOSS);
  assign bus.caught          = (r_state == S_CAUGHT);
  assign bus.active_slot     = r_slot;
  assign bus.catch_denied    = r_catchDenied;
endmodule

// File: tb/tb_battle_ctrl_n.sv
// Self-checking bench for battle_ctrl_n: directed scenarios plus randomized turns
// compared against a turn-level model of expected state/slot/denial sequences.
module tb_battle_ctrl_n;
  localparam int PARTY_N   = 3;
  localparam int MAX_CATCH = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   mSlot = 0;
  int   mCnt = 0;

  always #5 clk = ~clk;

  battle_ctrl_n_if #(.PARTY_N(PARTY_N)) bus ();

  battle_ctrl_n #(.PARTY_N(PARTY_N), .MAX_CATCH(MAX_CATCH)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // Expected {ai_dmg, p_dmg, heal, catch, catch_fail, switch, victory, loss, caught} per state code.
  function automatic logic [8:0] expFlags(int code);
    case (code)
      1:       return 9'b100000000;
      2:       return 9'b010000000;
      3:       return 9'b001000000;
      4:       return 9'b000100000;
      5:       return 9'b000010000;
      6:       return 9'b000001000;
      7:       return 9'b000000100;
      8:       return 9'b000000010;
      9:       return 9'b000000001;
      default: return 9'b000000000;
    endcase
  endfunction

  function automatic int pickSlot(int cur, logic [PARTY_N-1:0] alive);
    for (int k = 1; k < PARTY_N; k++) begin
      if (alive[(cur + k) % PARTY_N]) return (cur + k) % PARTY_N;
    end
    return -1;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input int expCode, input int expSlot, input bit expDenied);
    checkValue({tag, ".state"}, 32'(bus.state_code), expCode);
    checkValue({tag, ".strobes"},
               32'({bus.apply_ai_damage, bus.apply_p_damage, bus.p_heal, bus.catch, bus.catch_fail,
                    bus.switch_en, bus.victory, bus.loss, bus.caught}),
               32'(expFlags(expCode)));
    checkValue({tag, ".slot"}, 32'(bus.active_slot), expSlot);
    checkValue({tag, ".denied"}, 32'(bus.catch_denied), 32'(expDenied));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    mSlot = 0;
    mCnt = 0;
  endtask

  // Pulses go for one edge, then scrambles op/order to show they are latched.
  task automatic applyStimulus(input logic [1:0] op, input bit pf, input bit cs);
    bus.move_op = op;
    bus.p_faster = pf;
    bus.catch_success = cs;
    bus.go = 1'b1;
    step();
    bus.go = 1'b0;
    bus.move_op = 2'($urandom_range(0, 3));
    bus.p_faster = 1'($urandom_range(0, 1));
  endtask

  task automatic runTurn(input string tag, input logic [1:0] op, input bit pf, input bit cs, output bit ended);
    int codes[$];
    int slots[$];
    int denied[$];
    int newSlot;
    ended = 1'b0;
    case (op)
      2'b00: begin
        codes = pf ? '{1, 2, 0} : '{2, 1, 0};
        slots = '{mSlot, mSlot, mSlot};
        denied = '{0, 0, 0};
      end
      2'b11: begin
        codes = '{3, 2, 0};
        slots = '{mSlot, mSlot, mSlot};
        denied = '{0, 0, 0};
      end
      2'b01: begin
        if (mCnt < MAX_CATCH) begin
          mCnt++;
          codes = cs ? '{4, 9, 9} : '{4, 5, 2, 0};
          slots = '{mSlot, mSlot, mSlot, mSlot};
          denied = '{0, 0, 0, 0};
          ended = cs;
        end else begin
          codes = '{0, 0};
          slots = '{mSlot, mSlot};
          denied = '{1, 0};
        end
      end
      default: begin
        newSlot = pickSlot(mSlot, bus.party_alive);
        if (newSlot >= 0) begin
          codes = '{6, 2, 0};
          slots = '{mSlot, newSlot, newSlot};
          mSlot = newSlot;
        end else begin
          codes = '{0, 0};
          slots = '{mSlot, mSlot};
        end
        denied = '{0, 0, 0};
      end
    endcase
    applyStimulus(op, pf, cs);
    for (int i = 0; i < codes.size(); i++) begin
      checkOutput($sformatf("%s[%0d]", tag, i), codes[i], slots[i], denied[i] != 0);
      if (i < codes.size() - 1) step();
    end
  endtask

  initial begin
    bit ended;
    logic [PARTY_N-1:0] alive;
    bus.go = 1'b0;
    bus.move_op = 2'b00;
    bus.p_faster = 1'b0;
    bus.ai_dead = 1'b0;
    bus.party_alive = '1;
    bus.catch_success = 1'b0;

    $display("[TB] reset state");
    reset_n = 1'b0;
    bus.go = 1'b1;
    step();
    step();
    checkOutput("reset", 0, 0, 1'b0);
    bus.go = 1'b0;
    reset_n = 1'b1;
    step();
    checkOutput("idle", 0, 0, 1'b0);

    $display("[TB] attack turns");
    runTurn("atk_pfast", 2'b00, 1'b1, 1'b0, ended);
    runTurn("atk_aifast", 2'b00, 1'b0, 1'b0, ended);
    runTurn("heal", 2'b11, 1'b0, 1'b0, ended);

    $display("[TB] catch limit");
    doReset();
    for (int i = 0; i < MAX_CATCH + 2; i++) begin
      runTurn($sformatf("catch%0d", i), 2'b01, 1'b0, 1'b0, ended);
    end

    $display("[TB] forced switch mid-turn");
    doReset();
    runTurn("vswitch1", 2'b10, 1'b0, 1'b0, ended);
    runTurn("vswitch2", 2'b10, 1'b0, 1'b0, ended);
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("forced.ai", 2, 2, 1'b0);
    bus.party_alive = 3'b011;
    step();
    checkOutput("forced.sw", 6, 2, 1'b0);
    step();
    checkOutput("forced.menu", 0, 0, 1'b0);
    step();
    checkOutput("forced.noatk", 0, 0, 1'b0);
    mSlot = 0;

    $display("[TB] lone survivor switch request");
    doReset();
    bus.party_alive = 3'b001;
    runTurn("noswitch", 2'b10, 1'b0, 1'b0, ended);
    bus.party_alive = '1;

    $display("[TB] victory over loss and absorbing");
    doReset();
    bus.ai_dead = 1'b1;
    bus.party_alive = '0;
    step();
    checkOutput("victory", 7, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.go = 1'b1;
      bus.move_op = 2'($urandom_range(0, 3));
      bus.ai_dead = 1'($urandom_range(0, 1));
      bus.party_alive = PARTY_N'($urandom_range(0, 7));
      step();
      checkOutput($sformatf("victory.hold%0d", i), 7, 0, 1'b0);
    end
    bus.go = 1'b0;
    bus.ai_dead = 1'b0;
    bus.party_alive = '1;
    doReset();
    checkOutput("victory.reset", 0, 0, 1'b0);

    $display("[TB] loss and mid-turn overrides");
    bus.party_alive = '0;
    step();
    checkOutput("loss", 8, 0, 1'b0);
    bus.party_alive = '1;
    step();
    checkOutput("loss.hold", 8, 0, 1'b0);
    doReset();
    applyStimulus(2'b00, 1'b1, 1'b0);
    checkOutput("midvic.patk", 1, 0, 1'b0);
    bus.ai_dead = 1'b1;
    step();
    checkOutput("midvic", 7, 0, 1'b0);
    bus.ai_dead = 1'b0;
    doReset();
    applyStimulus(2'b00, 1'b1, 1'b0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    checkOutput("midreset", 0, 0, 1'b0);

    $display("[TB] randomized turns");
    doReset();
    for (int t = 0; t < 60; t++) begin
      alive = PARTY_N'($urandom_range(1, 7)) | PARTY_N'(1 << mSlot);
      bus.party_alive = alive;
      runTurn($sformatf("rnd%0d", t), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 5) == 0), ended);
      if (ended) begin
        doReset();
        checkOutput($sformatf("rnd%0d.reset", t), 0, 0, 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
